pcap_frame_proc: RTL

Frame-processing stage sitting directly upstream of the position-capture (PCAP) buffer in panda_top. Watches the enable, frame and capture system-bus bits and, per position channel, turns the sampled position into a raw, frame-delta or frame-midpoint value. Emits a single-cycle capture strobe with the processed position words for the PCAP buffer to store. Flags captures that occur outside an open frame.

---
 rtl/pcap_frame_proc_if.sv | 31 +++
 rtl/pcap_frame_proc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pcap_frame_proc_if.sv
// pcap_frame_proc bus: system-bus bits, framing config and positions in,
// processed positions, capture strobe and status out.
interface pcap_frame_proc_if #(
  parameter int NPOS = 4
);
  logic                enable_i;
  logic                frame_i;
  logic                capture_i;
  logic                framing_en_i;
  logic [2*NPOS-1:0]   frame_mode_i;
  logic [32*NPOS-1:0]  posn_i;
  logic [32*NPOS-1:0]  posn_o;
  logic                capture_o;
  logic                active_o;
  logic                frame_open_o;
  logic                error_o;

  modport master (
    output enable_i, frame_i, capture_i,
    output framing_en_i, frame_mode_i, posn_i,
    input  posn_o, capture_o, active_o,
    input  frame_open_o, error_o
  );

  modport slave (
    input  enable_i, frame_i, capture_i,
    input  framing_en_i, frame_mode_i, posn_i,
    output posn_o, capture_o, active_o,
    output frame_open_o, error_o
  );
endinterface

// File: rtl/pcap_frame_proc.sv
// PCAP frame processing: raw / frame-delta / frame-midpoint positions.
// Ports: clk_i, reset_i (sync, active-high), bus (slave side).
module pcap_frame_proc #(
  parameter int NPOS = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  pcap_frame_proc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_OPEN
  } state_t;

  state_t state_q, state_d;

  logic en_d, fr_d, cap_d;
  logic rise_en, rise_fr, rise_cap;
  logic was_open;

  logic [32*NPOS-1:0] start_q, start_d;
  logic [32*NPOS-1:0] posn_q, posn_d;
  logic cap_q, cap_n;
  logic err_q, err_n;

  function automatic logic [31:0] proc(
    input logic [1:0]  md,
    input logic [31:0] cur,
    input logic [31:0] st
  );
    logic [31:0] r;
    unique case (1'b1)
      md == 2'b01: r = cur - st;
      // 33-bit sum so the midpoint never overflows
      md == 2'b10: r = 32'(($signed({cur[31], cur})
                       + $signed({st[31], st})) >>> 1);
      default:     r = cur;
    endcase
    return r;
  endfunction

  assign rise_en  = bus.enable_i  & ~en_d;
  assign rise_fr  = bus.frame_i   & ~fr_d;
  assign rise_cap = bus.capture_i & ~cap_d;

  // an enable rise closes any frame before capture is judged
  assign was_open = (state_q == S_OPEN) && !rise_en;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    posn_d  = posn_q;
    cap_n   = 1'b0;
    err_n   = err_q;
    if (!bus.enable_i) begin
      state_d = S_IDLE;
    end else begin
      if (rise_en) begin
        state_d = S_ARMED;
        err_n   = 1'b0;
      end
      if (!bus.framing_en_i) begin
        if (rise_cap) begin
          cap_n  = 1'b1;
          posn_d = bus.posn_i;
        end
      end else begin
        if (rise_cap) begin
          if (was_open) begin
            cap_n = 1'b1;
            for (int k = 0; k < NPOS; k++) begin
              posn_d[32*k +: 32] = proc(
                bus.frame_mode_i[2*k +: 2],
                bus.posn_i[32*k +: 32],
                start_q[32*k +: 32]);
            end
          end else begin
            err_n = 1'b1;
          end
        end
        // reload after the capture so it sees the old start
        if (rise_fr) begin
          start_d = bus.posn_i;
          state_d = S_OPEN;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_d    <= 1'b0;
      fr_d    <= 1'b0;
      cap_d   <= 1'b0;
      start_q <= '0;
      posn_q  <= '0;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_d    <= bus.enable_i;
      fr_d    <= bus.frame_i;
      cap_d   <= bus.capture_i;
      start_q <= start_d;
      posn_q  <= posn_d;
      cap_q   <= cap_n;
      err_q   <= err_n;
    end
  end

  assign bus.posn_o       = posn_q;
  assign bus.capture_o    = cap_q;
  assign bus.error_o      = err_q;
  assign bus.active_o     = (state_q != S_IDLE);
  assign bus.frame_open_o = (state_q == S_OPEN);

endmodule
